// File: rtl/stream_memory_responder.sv
// rtl/stream_memory_responder.sv - AXI-Stream write buffer with burst read-back stream
// Optional macro STREAM_MEMORY_PKT_COUNT_EN adds the pkt_count output.
module stream_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                          axis_aclk,
  input  logic                          axis_areset,
  input  logic [DATA_WIDTH-1:0]         s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s01_axis_tstrb,
  input  logic                          s01_axis_tvalid,
  input  logic                          s01_axis_tlast,
  output logic                          s01_axis_tready,
  input  logic                          m01_axis_tready,
  output logic [DATA_WIDTH-1:0]         m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m01_axis_tstrb,
  output logic                          m01_axis_tvalid,
  output logic                          m01_axis_tlast,
  input  logic                          rd_start,
  output logic                          rd_done,
  output logic                          rd_empty,
  output logic [$clog2(DEPTH):0]        mem_count,
  output logic                          mem_full,
  output logic                          mem_empty
`ifdef STREAM_MEMORY_PKT_COUNT_EN
  ,
  output logic [15:0]                   pkt_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [SW-1:0]         strb_mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]         count_q, remain_q;
  logic                  wr_hs, rd_hs;
  logic                  start_burst, load_next, end_burst, empty_hit;

  assign s01_axis_tready = !axis_areset && (count_q < CW'(DEPTH));
  assign wr_hs           = s01_axis_tvalid && s01_axis_tready;
  assign rd_hs           = m01_axis_tvalid && m01_axis_tready;
  assign rd_ptr_nxt      = rd_ptr + AW'(1);
  assign mem_count       = count_q;
  assign mem_full        = (count_q == CW'(DEPTH));
  assign mem_empty       = (count_q == '0);

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_burst = 1'b0;
    load_next   = 1'b0;
    end_burst   = 1'b0;
    empty_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (count_q != '0) begin
            start_burst = 1'b1;
            state_d     = STREAM;
          end else begin
            empty_hit = 1'b1;
          end
        end
      end
      STREAM: begin
        if (rd_hs) begin
          if (m01_axis_tlast) begin
            end_burst = 1'b1;
            state_d   = IDLE;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge axis_aclk) begin
    if (wr_hs) begin
      data_mem[wr_ptr] <= s01_axis_tdata;
      strb_mem[wr_ptr] <= s01_axis_tstrb;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_hs) wr_ptr <= wr_ptr + AW'(1);
      if (rd_hs) rd_ptr <= rd_ptr_nxt;
      case ({wr_hs, rd_hs})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The burst length is frozen at start so words written mid-burst wait for the next one.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      m01_axis_tdata  <= '0;
      m01_axis_tstrb  <= '0;
      m01_axis_tvalid <= 1'b0;
      m01_axis_tlast  <= 1'b0;
      remain_q        <= '0;
      rd_done         <= 1'b0;
      rd_empty        <= 1'b0;
    end else begin
      rd_done  <= end_burst;
      rd_empty <= empty_hit;
      if (start_burst) begin
        m01_axis_tdata  <= data_mem[rd_ptr];
        m01_axis_tstrb  <= strb_mem[rd_ptr];
        m01_axis_tvalid <= 1'b1;
        m01_axis_tlast  <= (count_q == CW'(1));
        remain_q        <= count_q;
      end else if (load_next) begin
        m01_axis_tdata  <= data_mem[rd_ptr_nxt];
        m01_axis_tstrb  <= strb_mem[rd_ptr_nxt];
        m01_axis_tlast  <= (remain_q == CW'(2));
        remain_q        <= remain_q - CW'(1);
      end else if (end_burst) begin
        m01_axis_tdata  <= '0;
        m01_axis_tstrb  <= '0;
        m01_axis_tvalid <= 1'b0;
        m01_axis_tlast  <= 1'b0;
        remain_q        <= '0;
      end
    end
  end

`ifdef STREAM_MEMORY_PKT_COUNT_EN
  logic pkt_in;
  assign pkt_in = wr_hs && s01_axis_tlast;

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      pkt_count <= '0;
    end else if (pkt_in && !rd_done) begin
      if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
    end else if (rd_done && !pkt_in) begin
      if (pkt_count != 16'd0) pkt_count <= pkt_count - 16'd1;
    end
  end
`else
  logic tlast_unused;
  assign tlast_unused = s01_axis_tlast;
`endif

endmodule

// File: tb/tb_stream_memory_responder.sv
// tb/tb_stream_memory_responder.sv - scoreboard bench for stream_memory_responder
module tb_stream_memory_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        axis_areset;
  logic [31:0] s01_axis_tdata;
  logic [3:0]  s01_axis_tstrb;
  logic        s01_axis_tvalid;
  logic        s01_axis_tlast;
  logic        s01_axis_tready;
  logic        m01_axis_tready;
  logic [31:0] m01_axis_tdata;
  logic [3:0]  m01_axis_tstrb;
  logic        m01_axis_tvalid;
  logic        m01_axis_tlast;
  logic        rd_start;
  logic        rd_done;
  logic        rd_empty;
  logic [4:0]  mem_count;
  logic        mem_full;
  logic        mem_empty;
`ifdef STREAM_MEMORY_PKT_COUNT_EN
  logic [15:0] pkt_count;
`endif

  always #5 clk = ~clk;

  stream_memory_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .axis_aclk       (clk),
    .axis_areset     (axis_areset),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tstrb  (s01_axis_tstrb),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tready (s01_axis_tready),
    .m01_axis_tready (m01_axis_tready),
    .m01_axis_tdata  (m01_axis_tdata),
    .m01_axis_tstrb  (m01_axis_tstrb),
    .m01_axis_tvalid (m01_axis_tvalid),
    .m01_axis_tlast  (m01_axis_tlast),
    .rd_start        (rd_start),
    .rd_done         (rd_done),
    .rd_empty        (rd_empty),
    .mem_count       (mem_count),
    .mem_full        (mem_full),
    .mem_empty       (mem_empty)
`ifdef STREAM_MEMORY_PKT_COUNT_EN
    ,
    .pkt_count       (pkt_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of stored {strb,data} plus the read-side state.
  logic [35:0] sb[$];
  bit          mon_en = 1'b0;
  bit          exp_valid = 1'b0;
  int          burst_left = 0;
  bit          pend_done = 1'b0;
  bit          pend_empty = 1'b0;
  int          hs_count = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  int          exp_pkt = 0;

  always @(negedge clk) begin
    bit exp_ready, hs, start, wr, inc, dec;
    logic [35:0] head;
    if (mon_en) begin
      exp_ready = !axis_areset && (sb.size() < DEPTH);
      chk("mem_count", 64'(mem_count), 64'(sb.size()));
      chk("mem_full", 64'(mem_full), 64'(sb.size() == DEPTH));
      chk("mem_empty", 64'(mem_empty), 64'(sb.size() == 0));
      chk("s_tready", 64'(s01_axis_tready), 64'(exp_ready));
      chk("m_tvalid", 64'(m01_axis_tvalid), 64'(exp_valid));
      chk("rd_done", 64'(rd_done), 64'(pend_done));
      chk("rd_empty", 64'(rd_empty), 64'(pend_empty));
`ifdef STREAM_MEMORY_PKT_COUNT_EN
      chk("pkt_count", 64'(pkt_count), 64'(exp_pkt));
`endif
      if (!exp_valid) begin
        chk("idle_tdata", 64'(m01_axis_tdata), 64'd0);
        chk("idle_tstrb", 64'(m01_axis_tstrb), 64'd0);
      end
      if (prev_stall) begin
        chk("stall_tdata", 64'(m01_axis_tdata), 64'(prev_data));
        chk("stall_tlast", 64'(m01_axis_tlast), 64'(prev_last));
      end
      hs = exp_valid && m01_axis_tready;
      if (m01_axis_tvalid && m01_axis_tready && !axis_areset) hs_count++;
      if (hs && sb.size() > 0) begin
        head = sb[0];
        chk("rd_tdata", 64'(m01_axis_tdata), 64'(head[31:0]));
        chk("rd_tstrb", 64'(m01_axis_tstrb), 64'(head[35:32]));
        chk("rd_tlast", 64'(m01_axis_tlast), 64'(burst_left == 1));
      end
      prev_stall = exp_valid && !m01_axis_tready && !axis_areset;
      prev_data  = m01_axis_tdata;
      prev_last  = m01_axis_tlast;

      if (axis_areset) begin
        sb.delete();
        exp_valid  = 1'b0;
        burst_left = 0;
        pend_done  = 1'b0;
        pend_empty = 1'b0;
        exp_pkt    = 0;
        prev_stall = 1'b0;
      end else begin
        start = rd_start && !exp_valid && (sb.size() > 0);
        wr    = s01_axis_tvalid && exp_ready;
        inc   = wr && s01_axis_tlast;
        dec   = pend_done;
        if (inc && !dec && exp_pkt < 16'hFFFF) exp_pkt++;
        if (dec && !inc && exp_pkt > 0) exp_pkt--;
        pend_empty = rd_start && !exp_valid && (sb.size() == 0);
        pend_done  = hs && (burst_left == 1);
        if (hs) begin
          void'(sb.pop_front());
          burst_left--;
          if (burst_left == 0) exp_valid = 1'b0;
        end
        if (start) begin
          burst_left = sb.size();
          exp_valid  = 1'b1;
        end
        if (wr) sb.push_back({s01_axis_tstrb, s01_axis_tdata});
      end
    end
  end

  task automatic wr(input logic [31:0] d, input logic [3:0] s, input logic l);
    s01_axis_tdata  = d;
    s01_axis_tstrb  = s;
    s01_axis_tlast  = l;
    s01_axis_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (s01_axis_tready) begin
        tick();
        s01_axis_tvalid = 1'b0;
        s01_axis_tlast  = 1'b0;
        return;
      end
      tick();
    end
    chk("wr_timeout", 64'd0, 64'd1);
    s01_axis_tvalid = 1'b0;
    s01_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 100 && !rd_done; k++) tick();
    chk(nm, 64'(rd_done), 64'd1);
  endtask

  task automatic pulse_start();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    int          cnt;
  } vec_t;

  initial begin
    vec_t tv[4];
    bit   pat[6];
    tv[0] = '{32'h11, 4'hF, 1'b0, 1};
    tv[1] = '{32'h22, 4'hF, 1'b0, 2};
    tv[2] = '{32'h33, 4'hF, 1'b0, 3};
    tv[3] = '{32'h44, 4'hF, 1'b1, 4};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    axis_areset     = 1'b1;
    s01_axis_tdata  = '0;
    s01_axis_tstrb  = '0;
    s01_axis_tvalid = 1'b0;
    s01_axis_tlast  = 1'b0;
    m01_axis_tready = 1'b0;
    rd_start        = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    chk("rst_empty", 64'(mem_empty), 64'd1);
    chk("rst_tready", 64'(s01_axis_tready), 64'd0);
    chk("rst_count", 64'(mem_count), 64'd0);
    chk("rst_tvalid", 64'(m01_axis_tvalid), 64'd0);
    axis_areset = 1'b0;
    tick();

    // Basic write/read of a four-word packet.
    for (int i = 0; i < 4; i++) begin
      wr(tv[i].d, tv[i].s, tv[i].l);
      chk("t1_count", 64'(mem_count), 64'(tv[i].cnt));
    end
    m01_axis_tready = 1'b1;
    pulse_start();
    chk("t1_latency", 64'(m01_axis_tvalid), 64'd1);
    chk("t1_first", 64'(m01_axis_tdata), 64'h11);
    wait_done("t1_done");
    chk("t1_count_end", 64'(mem_count), 64'd0);

    // Fill to DEPTH, hold a 17th word until one slot frees.
    m01_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) wr(32'(i), 4'hF, 1'(i == 15));
    chk("t2_full", 64'(mem_full), 64'd1);
    chk("t2_tready", 64'(s01_axis_tready), 64'd0);
    s01_axis_tdata  = 32'hAA;
    s01_axis_tstrb  = 4'h3;
    s01_axis_tvalid = 1'b1;
    repeat (3) tick();
    chk("t2_held", 64'(mem_count), 64'd16);
    m01_axis_tready = 1'b1;
    pulse_start();
    tick();
    m01_axis_tready = 1'b0;
    tick();
    s01_axis_tvalid = 1'b0;
    chk("t2_refill", 64'(mem_count), 64'd16);
    m01_axis_tready = 1'b1;
    wait_done("t2_done");
    pulse_start();
    wait_done("t2_aa_done");

    // Burst of three under a stalling consumer.
    wr(32'h301, 4'h1, 1'b0);
    wr(32'h302, 4'h2, 1'b0);
    wr(32'h303, 4'h4, 1'b1);
    m01_axis_tready = 1'b0;
    pulse_start();
    hs_count = 0;
    for (int i = 0; i < 6; i++) begin
      m01_axis_tready = pat[i];
      tick();
    end
    chk("t3_done", 64'(rd_done), 64'd1);
    chk("t3_handshakes", 64'(hs_count), 64'd3);

    // Read request on an empty buffer, then a request during a burst.
    m01_axis_tready = 1'b1;
    pulse_start();
    chk("t4_empty_pulse", 64'(rd_empty), 64'd1);
    chk("t4_no_valid", 64'(m01_axis_tvalid), 64'd0);
    tick();
    chk("t4_empty_one", 64'(rd_empty), 64'd0);
    for (int i = 0; i < 4; i++) wr(32'h400 + 32'(i), 4'hF, 1'(i == 3));
    m01_axis_tready = 1'b0;
    pulse_start();
    tick();
    pulse_start();
    m01_axis_tready = 1'b1;
    wait_done("t4_done");
    repeat (3) tick();
    chk("t4_no_extra", 64'(m01_axis_tvalid), 64'd0);

    // Pointer wrap with writes landing during the burst.
    axis_areset = 1'b1;
    tick();
    axis_areset = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) wr(32'hA00 + 32'(i), 4'hF, 1'b0);
    pulse_start();
    wait_done("t5_first_done");
    for (int i = 0; i < 8; i++) wr(32'hB0 + 32'(i), 4'hF, 1'(i == 7));
    pulse_start();
    chk("t5_first_word", 64'(m01_axis_tdata), 64'hB0);
    s01_axis_tdata  = 32'hC0;
    s01_axis_tvalid = 1'b1;
    tick();
    s01_axis_tdata  = 32'hC1;
    tick();
    s01_axis_tvalid = 1'b0;
    wait_done("t5_done");
    chk("t5_count", 64'(mem_count), 64'd2);
    pulse_start();
    wait_done("t5_tail_done");

    // Reset while the second word of a burst is presented.
    for (int i = 0; i < 4; i++) wr(32'hD0 + 32'(i), 4'hF, 1'(i == 3));
    pulse_start();
    tick();
    chk("t6_second", 64'(m01_axis_tdata), 64'hD1);
    axis_areset = 1'b1;
    tick();
    chk("t6_tvalid", 64'(m01_axis_tvalid), 64'd0);
    chk("t6_count", 64'(mem_count), 64'd0);
    chk("t6_no_done", 64'(rd_done), 64'd0);
`ifdef STREAM_MEMORY_PKT_COUNT_EN
    chk("t6_pkt", 64'(pkt_count), 64'd0);
`endif
    axis_areset = 1'b0;
    repeat (2) tick();
    chk("t6_no_done_late", 64'(rd_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
